row_accumulate_sequencer: RTL and testbench

- Control sequencer for the row dot-product datapath: an NI-wide pipelined adder tree feeding a single feedback accumulator adder (zero/feedback mux on the accumulator input).
- Accepts a row length in chunks, then pulls chunks from the operand source with a valid/ready handshake. Each accepted chunk is issued to the tree.
- Each chunk is spaced so its tree result meets the accumulator exactly when the previous accumulation has completed.
- Drives accumulator clear/go controls and signals row completion.
- Pure control. No data passes through this block.

---
 rtl/row_accumulate_sequencer.sv | 129 ++++++++++++
 tb/tb_row_accumulate_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/row_accumulate_sequencer.sv
// Row dot-product control: paces chunk issue to the adder tree so each tree result
// meets the feedback accumulator just as the previous accumulation completes.
module row_accumulate_sequencer #(
    parameter int NI       = 8,
    parameter int CHUNK_W  = 8,
    parameter int TREE_LAT = 9,
    parameter int ACC_LAT  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CHUNK_W-1:0] num_chunks,
    output logic               busy,
    output logic               chunk_ready,
    input  logic               chunk_valid,
    output logic               tree_go,
    output logic               acc_go,
    output logic               acc_clear,
    output logic [CHUNK_W-1:0] chunk_idx,
    output logic               row_done,
    output logic               row_empty
);

    localparam int DRAIN_CYC = TREE_LAT + ACC_LAT - 1;
    // NI sizes nothing in this block; a non-positive NI only widens the counter harmlessly.
    localparam int CNT_W = $clog2(DRAIN_CYC + 1) + ((NI > 0) ? 0 : 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CHUNK_W-1:0]  num_q, num_d;
    logic [CHUNK_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic                first_q, first_d;
    logic                empty_q, empty_d;
    logic [TREE_LAT-1:0] pv_q, pv_d;
    logic [TREE_LAT-1:0] pf_q, pf_d;
    logic                transfer;

    assign chunk_ready = (state_q == S_ISSUE) && (gap_q == '0);
    assign transfer    = chunk_ready & chunk_valid;
    assign tree_go     = transfer;
    assign busy        = (state_q != S_IDLE);
    assign acc_go      = pv_q[TREE_LAT-1];
    assign acc_clear   = pf_q[TREE_LAT-1];
    assign chunk_idx   = idx_q;
    assign row_done    = (state_q == S_DONE);
    assign row_empty   = row_done & empty_q;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        first_d = first_q;
        empty_d = empty_q;
        pv_d    = (pv_q << 1) | TREE_LAT'(transfer);
        pf_d    = (pf_q << 1) | TREE_LAT'(transfer & first_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_chunks;
                    idx_d   = '0;
                    gap_d   = '0;
                    first_d = 1'b1;
                    empty_d = (num_chunks == '0);
                    state_d = (num_chunks == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (transfer) begin
                    idx_d   = idx_q + 1'b1;
                    first_d = 1'b0;
                    // Final acc_go lands TREE_LAT after this transfer; one countdown
                    // covers that wait plus the ACC_LAT feedback settle.
                    if (idx_d == num_q) begin
                        state_d = S_DRAIN;
                        gap_d   = CNT_W'(DRAIN_CYC);
                    end else begin
                        gap_d = CNT_W'(ACC_LAT - 1);
                    end
                end else if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (gap_q <= CNT_W'(1)) begin
                    gap_d   = '0;
                    state_d = S_DONE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            first_q <= 1'b0;
            empty_q <= 1'b0;
            pv_q    <= '0;
            pf_q    <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            first_q <= first_d;
            empty_q <= empty_d;
            pv_q    <= pv_d;
            pf_q    <= pf_d;
        end
    end

endmodule

// File: tb/tb_row_accumulate_sequencer.sv
// Scoreboard bench for row_accumulate_sequencer: two latency configurations share one
// stimulus stream; each has a cycle-level reference model feeding expected-event queues.
module tb_row_accumulate_sequencer;

    localparam int CW   = 8;
    localparam int NCFG = 2;
    localparam int TL_A [NCFG] = '{9, 4};
    localparam int AL_A [NCFG] = '{3, 1};

    typedef struct {
        int unsigned cyc;
        int unsigned val;
        int unsigned aux;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          chunk_valid = 1'b0;
    logic [CW-1:0] num_chunks = '0;
    int unsigned   cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    logic          busy_w  [NCFG];
    logic          ready_w [NCFG];
    logic          tree_w  [NCFG];
    logic          acc_w   [NCFG];
    logic          clr_w   [NCFG];
    logic          done_w  [NCFG];
    logic          empty_w [NCFG];
    logic [CW-1:0] idx_w   [NCFG];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int TL = TL_A[gi];
        localparam int AL = AL_A[gi];

        row_accumulate_sequencer #(
            .NI(8), .CHUNK_W(CW), .TREE_LAT(TL), .ACC_LAT(AL)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
            .busy(busy_w[gi]), .chunk_ready(ready_w[gi]), .chunk_valid(chunk_valid),
            .tree_go(tree_w[gi]), .acc_go(acc_w[gi]), .acc_clear(clr_w[gi]),
            .chunk_idx(idx_w[gi]), .row_done(done_w[gi]), .row_empty(empty_w[gi])
        );

        ev_t         q_tree[$];
        ev_t         q_acc[$];
        ev_t         q_done[$];
        bit          rowing = 0;
        bit          first_m = 0;
        bit          exp_busy = 0;
        bit          exp_ready = 0;
        int unsigned n_m = 0;
        int unsigned cnt_m = 0;
        int unsigned earliest = 0;
        int unsigned idle_at = 0;
        int unsigned pend_l = 0;

        // Reference model: a row is busy from acceptance until its done cycle; a chunk
        // moves on the first valid cycle at least ACC_LAT after the previous one.
        always @(negedge clk) begin : model
            if (!rst_n) begin
                q_tree.delete();
                q_acc.delete();
                q_done.delete();
                rowing    = 0;
                idle_at   = 0;
                exp_busy  = 0;
                exp_ready = 0;
            end else begin
                exp_busy  = rowing || (cyc < idle_at);
                exp_ready = rowing && (cyc >= earliest);
                if (exp_ready && chunk_valid) begin
                    q_tree.push_back('{cyc, cnt_m, 0});
                    q_acc.push_back('{cyc + TL, first_m, 0});
                    first_m  = 0;
                    cnt_m++;
                    earliest = cyc + AL;
                    if (cnt_m == n_m) begin
                        q_done.push_back('{cyc + TL + AL, 0, n_m});
                        idle_at = cyc + TL + AL + 1;
                        rowing  = 0;
                    end
                end else if (!exp_busy && start) begin
                    n_m   = num_chunks;
                    cnt_m = 0;
                    if (n_m == 0) begin
                        q_done.push_back('{cyc + 1, 1, 0});
                        idle_at = cyc + 2;
                    end else begin
                        rowing   = 1;
                        first_m  = 1;
                        earliest = cyc + 1;
                    end
                end
            end
        end

        always @(negedge clk) begin : monitor
            bit  e;
            ev_t x;
            #1;
            if (rst_n) begin
                chk($sformatf("cfg%0d busy", gi), busy_w[gi], exp_busy);
                chk($sformatf("cfg%0d chunk_ready", gi), ready_w[gi], exp_ready);

                e = (q_tree.size() > 0) && (q_tree[0].cyc == cyc);
                if (e || tree_w[gi]) begin
                    chk($sformatf("cfg%0d tree_go", gi), tree_w[gi], e);
                    if (e) begin
                        x = q_tree.pop_front();
                        chk($sformatf("cfg%0d chunk_idx@transfer", gi), idx_w[gi], x.val);
                    end
                end

                e = (q_acc.size() > 0) && (q_acc[0].cyc == cyc);
                if (e || acc_w[gi]) begin
                    chk($sformatf("cfg%0d acc_go", gi), acc_w[gi], e);
                    if (e) begin
                        x = q_acc.pop_front();
                        chk($sformatf("cfg%0d acc_clear", gi), clr_w[gi], x.val);
                    end
                end else if (clr_w[gi]) begin
                    chk($sformatf("cfg%0d stray acc_clear", gi), clr_w[gi], 0);
                end

                e = (q_done.size() > 0) && (q_done[0].cyc == cyc);
                if (e || done_w[gi]) begin
                    chk($sformatf("cfg%0d row_done", gi), done_w[gi], e);
                    if (e) begin
                        x = q_done.pop_front();
                        chk($sformatf("cfg%0d row_empty", gi), empty_w[gi], x.val);
                        chk($sformatf("cfg%0d chunk_idx@done", gi), idx_w[gi], x.aux);
                    end
                end
            end
            pend_l = q_tree.size() + q_acc.size() + q_done.size();
        end
    end

    task automatic drive(input bit st, input int unsigned n, input bit v);
        @(posedge clk);
        #1;
        start       = st;
        num_chunks  = CW'(n);
        chunk_valid = v;
    endtask

    task automatic run(input int unsigned cycles, input bit v);
        repeat (cycles) drive(1'b0, 0, v);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("%s cfg%0d busy", tag, i), busy_w[i], 0);
            chk($sformatf("%s cfg%0d chunk_ready", tag, i), ready_w[i], 0);
            chk($sformatf("%s cfg%0d tree_go", tag, i), tree_w[i], 0);
            chk($sformatf("%s cfg%0d acc_go", tag, i), acc_w[i], 0);
            chk($sformatf("%s cfg%0d acc_clear", tag, i), clr_w[i], 0);
            chk($sformatf("%s cfg%0d row_done", tag, i), done_w[i], 0);
            chk($sformatf("%s cfg%0d row_empty", tag, i), empty_w[i], 0);
            chk($sformatf("%s cfg%0d chunk_idx", tag, i), idx_w[i], 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst_n = 1'b1;

        // basic row, then a source that stalls before supplying chunks
        drive(1'b1, 3, 1'b1);
        run(25, 1'b1);
        drive(1'b1, 2, 1'b0);
        run(5, 1'b0);
        run(25, 1'b1);

        // empty row
        drive(1'b1, 0, 1'b0);
        run(4, 1'b0);

        // start held high through ISSUE, DRAIN and DONE with changing num_chunks
        drive(1'b1, 3, 1'b1);
        repeat (30) drive(1'b1, $urandom_range(1, 9), 1'b1);
        run(60, 1'b1);

        // asynchronous reset between the second and third transfer
        drive(1'b1, 5, 1'b1);
        run(4, 1'b1);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        start       = 1'b0;
        chunk_valid = 1'b0;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0);
        drive(1'b1, 2, 1'b1);
        run(25, 1'b1);

        // longest legal row
        drive(1'b1, 255, 1'b1);
        run(255 * 3 + 20, 1'b1);

        // random traffic
        repeat (3000) drive($urandom_range(0, 7) == 0, $urandom_range(0, 6),
                            $urandom_range(0, 2) != 0);
        run(80, 1'b1);
        run(5, 1'b0);

        chk("cfg0 pending expectations", g_cfg[0].pend_l, 0);
        chk("cfg1 pending expectations", g_cfg[1].pend_l, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
